if_fetch_queue: RTL and testbench

IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

---
 rtl/if_fetch_queue.sv | 149 ++++++++++++++
 tb/tb_if_fetch_queue.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// Instruction fetch queue: issues sequential fetches to the instruction SRAM, tracks in-flight
// requests and buffers returned instructions for decode. Define IFQ_BYPASS_EN for same-cycle bypass.
module if_fetch_queue #(
    parameter logic [31:0] RESET_PC        = 32'h1c000000,
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    input  logic        out_ready
);

    localparam int QAW = $clog2(DEPTH);
    localparam int QCW = $clog2(DEPTH + 1);
    localparam int CSW = QCW + 1;
    localparam int OCW = $clog2(MAX_OUTSTANDING + 1);
    localparam int FAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [31:0]    fetch_pc;
    logic [OCW-1:0] outstanding;
    logic [OCW-1:0] discard_cnt;
    logic [QCW-1:0] queue_count;
    logic [QAW-1:0] q_wr_ptr;
    logic [QAW-1:0] q_rd_ptr;
    logic [FAW-1:0] f_wr_ptr;
    logic [FAW-1:0] f_rd_ptr;

    logic [31:0] q_pc   [DEPTH];
    logic [31:0] q_inst [DEPTH];
    logic [31:0] f_pc   [MAX_OUTSTANDING];

    logic [CSW-1:0] credit_used;
    logic [31:0]    resp_pc;
    logic           accept;
    logic           resp_valid;
    logic           resp_keep;
    logic           queue_empty;
    logic           bypass;
    logic           q_push;
    logic           q_pop;

    function automatic logic [FAW-1:0] wrap_inc(input logic [FAW-1:0] p);
        if (int'(p) == MAX_OUTSTANDING - 1)
            return '0;
        else
            return p + FAW'(1);
    endfunction

    assign credit_used = CSW'(outstanding) + CSW'(queue_count);
    assign inst_req    = ~reset & ~redirect_valid
                       & (outstanding < OCW'(MAX_OUTSTANDING))
                       & (credit_used < CSW'(DEPTH));
    assign inst_addr   = fetch_pc;
    assign accept      = inst_req & inst_addr_ok;

    // A response with nothing outstanding is ignored so the counters cannot underflow.
    assign resp_valid  = inst_data_ok & (outstanding != '0);
    assign resp_pc     = f_pc[f_rd_ptr];
    assign resp_keep   = resp_valid & ~redirect_valid & (discard_cnt == '0);
    assign queue_empty = (queue_count == '0);

`ifdef IFQ_BYPASS_EN
    assign bypass = resp_keep & queue_empty;
`else
    assign bypass = 1'b0;
`endif

    assign out_valid = ~reset & (~queue_empty | bypass);
    assign q_pop     = out_valid & out_ready & ~bypass & ~redirect_valid;
    assign q_push    = resp_keep & ~(bypass & out_ready);

    always_comb begin
        out_pc   = '0;
        out_inst = '0;
        if (out_valid) begin
            if (bypass) begin
                out_pc   = resp_pc;
                out_inst = inst_rdata;
            end else begin
                out_pc   = q_pc[q_rd_ptr];
                out_inst = q_inst[q_rd_ptr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            discard_cnt <= '0;
            queue_count <= '0;
            q_wr_ptr    <= '0;
            q_rd_ptr    <= '0;
            f_wr_ptr    <= '0;
            f_rd_ptr    <= '0;
        end else begin
            if (redirect_valid)
                fetch_pc <= redirect_pc;
            else if (accept)
                fetch_pc <= fetch_pc + 32'd4;

            outstanding <= outstanding + OCW'(accept) - OCW'(resp_valid);

            if (accept)
                f_wr_ptr <= wrap_inc(f_wr_ptr);
            if (resp_valid)
                f_rd_ptr <= wrap_inc(f_rd_ptr);

            // Every request still in flight at a redirect is stale, including ones already
            // marked for discard, so the count tracks the surviving outstanding requests.
            if (redirect_valid)
                discard_cnt <= outstanding - OCW'(resp_valid);
            else if (resp_valid && discard_cnt != '0)
                discard_cnt <= discard_cnt - OCW'(1);

            if (redirect_valid) begin
                queue_count <= '0;
                q_wr_ptr    <= '0;
                q_rd_ptr    <= '0;
            end else begin
                queue_count <= queue_count + QCW'(q_push) - QCW'(q_pop);
                if (q_push)
                    q_wr_ptr <= q_wr_ptr + QAW'(1);
                if (q_pop)
                    q_rd_ptr <= q_rd_ptr + QAW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            f_pc[f_wr_ptr] <= fetch_pc;
        if (q_push) begin
            q_pc[q_wr_ptr]   <= resp_pc;
            q_inst[q_wr_ptr] <= inst_rdata;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: SRAM model answering one cycle after accept plus a scoreboard
// of expected {pc, inst} entries that is checked whenever decode consumes an instruction.
module tb_if_fetch_queue;

    localparam logic [31:0] RESET_PC = 32'h1c000000;
    localparam int          MAX_OUT  = 2;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_ready;

    int tests_run;
    int tests_failed;
    int n_accept;
    int cyc;
    int tb_discard;
    logic        resp_en;
    logic [31:0] tb_fetch_pc;

    logic [31:0] sram_q[$];
    logic [63:0] exp_q[$];
    logic [31:0] pop_pc_log[$];
    int          pop_cyc_log[$];

    if_fetch_queue dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_req       (inst_req),
        .inst_addr      (inst_addr),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .inst_rdata     (inst_rdata),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_ready      (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk_inst(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5a5a_a5a5;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_log(input string tag, input int idx, input logic [31:0] exp);
        if (idx < pop_pc_log.size())
            check(tag, pop_pc_log[idx], exp);
        else
            check({tag, "_count"}, 32'(pop_pc_log.size()), 32'(idx + 1));
    endtask

    task automatic drive_sram();
        if (!reset && resp_en && sram_q.size() > 0) begin
            inst_data_ok = 1'b1;
            inst_rdata   = mk_inst(sram_q[0]);
        end else begin
            inst_data_ok = 1'b0;
            inst_rdata   = 32'hdead_beef;
        end
    endtask

    task automatic process();
        logic [31:0] p;
        logic [63:0] e;
        if (reset) begin
            check("rst_inst_req", 32'(inst_req), 32'd0);
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_out_pc", out_pc, 32'd0);
            check("rst_out_inst", out_inst, 32'd0);
            sram_q.delete();
            exp_q.delete();
            tb_discard  = 0;
            tb_fetch_pc = RESET_PC;
        end else begin
            if (inst_data_ok) begin
                p = sram_q.pop_front();
                if (!redirect_valid) begin
                    if (tb_discard > 0) tb_discard--;
                    else exp_q.push_back({p, mk_inst(p)});
                end
            end
            if (redirect_valid) begin
                exp_q.delete();
                tb_discard = sram_q.size();
            end else if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("out_valid_unexpected", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_pc", out_pc, e[63:32]);
                    check("out_inst", out_inst, e[31:0]);
                    pop_pc_log.push_back(out_pc);
                    pop_cyc_log.push_back(cyc);
                end
            end
            if (inst_req && inst_addr_ok) begin
                check("inst_addr", inst_addr, tb_fetch_pc);
                sram_q.push_back(inst_addr);
                check("outstanding_over_max", 32'(sram_q.size() > MAX_OUT), 32'd0);
                tb_fetch_pc = tb_fetch_pc + 32'd4;
                n_accept++;
            end
            if (redirect_valid) tb_fetch_pc = redirect_pc;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        process();
        @(posedge clk);
        #1;
        drive_sram();
        cyc++;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        inst_addr_ok   = 1'b0;
        out_ready      = 1'b0;
        resp_en        = 1'b0;
        drive_sram();
        cycle();
        cycle();
        reset = 1'b0;
        drive_sram();
        pop_pc_log.delete();
        pop_cyc_log.delete();
        n_accept = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tests_run = 0; tests_failed = 0; cyc = 0; n_accept = 0; tb_discard = 0;
        tb_fetch_pc = RESET_PC;

        // Reset state and first request after release
        do_reset();
        #1;
        check("post_rst_req", 32'(inst_req), 32'd1);
        check("post_rst_addr", inst_addr, RESET_PC);
        check("post_rst_valid", 32'(out_valid), 32'd0);

        // Streaming with one-cycle SRAM latency and decode always ready
        do_reset();
        inst_addr_ok = 1'b1; out_ready = 1'b1; resp_en = 1'b1; drive_sram();
        repeat (8) cycle();
        inst_addr_ok = 1'b0;
        repeat (6) cycle();
        check_log("stream_pc0", 0, 32'h1c000000);
        check_log("stream_pc1", 1, 32'h1c000004);
        check_log("stream_pc2", 2, 32'h1c000008);
        if (pop_cyc_log.size() >= 3)
            check("stream_consecutive", 32'(pop_cyc_log[2] - pop_cyc_log[0]), 32'd2);
        check("stream_drained", 32'(exp_q.size()), 32'd0);

        // Decode stalled: fill to DEPTH then drain in order
        do_reset();
        inst_addr_ok = 1'b1; out_ready = 1'b0; resp_en = 1'b1; drive_sram();
        repeat (12) cycle();
        #1;
        check("full_accepts", 32'(n_accept), 32'd4);
        check("full_req_low", 32'(inst_req), 32'd0);
        check("full_qlen", 32'(exp_q.size()), 32'd4);
        check("full_head_pc", out_pc, 32'h1c000000);
        inst_addr_ok = 1'b0; out_ready = 1'b1;
        repeat (6) cycle();
        check_log("drain_pc0", 0, 32'h1c000000);
        check_log("drain_pc1", 1, 32'h1c000004);
        check_log("drain_pc2", 2, 32'h1c000008);
        check_log("drain_pc3", 3, 32'h1c00000c);

        // Redirect with two requests outstanding and no responses yet
        do_reset();
        inst_addr_ok = 1'b1; out_ready = 1'b1; resp_en = 1'b0; drive_sram();
        repeat (3) cycle();
        #1;
        check("redir_outstanding", 32'(sram_q.size()), 32'd2);
        check("redir_req_blocked", 32'(inst_req), 32'd0);
        redirect_valid = 1'b1; redirect_pc = 32'h1c000100;
        cycle();
        redirect_valid = 1'b0; resp_en = 1'b1; drive_sram();
        #1;
        check("redir_addr", inst_addr, 32'h1c000100);
        check("redir_out_valid", 32'(out_valid), 32'd0);
        repeat (8) cycle();
        inst_addr_ok = 1'b0;
        repeat (4) cycle();
        check_log("redir_pc0", 0, 32'h1c000100);
        check_log("redir_pc1", 1, 32'h1c000104);

        // Redirect in the same cycle as a response with two outstanding
        do_reset();
        inst_addr_ok = 1'b1; out_ready = 1'b1; resp_en = 1'b0; drive_sram();
        repeat (2) cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h1c000200; resp_en = 1'b1; drive_sram();
        cycle();
        redirect_valid = 1'b0;
        repeat (10) cycle();
        inst_addr_ok = 1'b0;
        repeat (4) cycle();
        check_log("redir_dok_pc0", 0, 32'h1c000200);
        check_log("redir_dok_pc1", 1, 32'h1c000204);
        check("redir_dok_discard", 32'(dut.discard_cnt), 32'd0);

        // SRAM not accepting: request and address hold
        do_reset();
        out_ready = 1'b1; resp_en = 1'b1; drive_sram();
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_req", 32'(inst_req), 32'd1);
            check("stall_addr", inst_addr, RESET_PC);
            cycle();
        end
        inst_addr_ok = 1'b1;
        cycle();
        inst_addr_ok = 1'b0;
        #1;
        check("stall_advance", inst_addr, 32'h1c000004);
        repeat (4) cycle();

        // Bypass latency on an empty queue
        do_reset();
        inst_addr_ok = 1'b1; out_ready = 1'b1; resp_en = 1'b1; drive_sram();
        cycle();
        inst_addr_ok = 1'b0;
        #1;
`ifdef IFQ_BYPASS_EN
        check("byp_same_cycle", 32'(out_valid), 32'd1);
        check("byp_same_pc", out_pc, RESET_PC);
`else
        check("byp_same_cycle", 32'(out_valid), 32'd0);
`endif
        cycle();
        #1;
`ifdef IFQ_BYPASS_EN
        check("byp_qcount", 32'(dut.queue_count), 32'd0);
        check("byp_next_valid", 32'(out_valid), 32'd0);
`else
        check("byp_qcount", 32'(dut.queue_count), 32'd1);
        check("byp_next_valid", 32'(out_valid), 32'd1);
        check("byp_next_pc", out_pc, RESET_PC);
`endif
        repeat (3) cycle();

        // Fetch address wraps modulo 2^32
        do_reset();
        inst_addr_ok = 1'b1; out_ready = 1'b1; resp_en = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hffff_fffc; drive_sram();
        cycle();
        redirect_valid = 1'b0;
        repeat (6) cycle();
        inst_addr_ok = 1'b0;
        repeat (5) cycle();
        check_log("wrap_pc0", 0, 32'hffff_fffc);
        check_log("wrap_pc1", 1, 32'h0000_0000);

        // Random traffic with occasional redirects, then drain
        do_reset();
        for (int i = 0; i < 400; i++) begin
            inst_addr_ok   = ($urandom_range(0, 3) != 0);
            out_ready      = ($urandom_range(0, 2) != 0);
            resp_en        = ($urandom_range(0, 1) != 0);
            redirect_valid = !redirect_valid && ($urandom_range(0, 19) == 0);
            redirect_pc    = {$urandom_range(0, 32'h3fff_ffff), 2'b00} ^ 32'h1c00_0000;
            drive_sram();
            cycle();
        end
        redirect_valid = 1'b0; inst_addr_ok = 1'b0; resp_en = 1'b1; out_ready = 1'b1;
        drive_sram();
        repeat (12) cycle();
        check("rand_exp_drained", 32'(exp_q.size()), 32'd0);
        check("rand_sram_drained", 32'(sram_q.size()), 32'd0);
        check("rand_pops_seen", 32'(pop_pc_log.size() > 20), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
